// File: rtl/cv32e40x_pkg.sv
// Shared types for the MPU slice: OBI bundles, MPU status,
// PMA region attributes and the MPU order-queue entry.
package cv32e40x_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  memtype;
    } obi_inst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_inst_resp_t;

    typedef enum logic [1:0] {
        MPU_OK       = 2'h0,
        MPU_RE_FAULT = 2'h1,
        MPU_WR_FAULT = 2'h2
    } mpu_status_e;

    typedef struct packed {
        obi_inst_resp_t bus_resp;
        mpu_status_e    mpu_status;
    } inst_resp_t;

    typedef struct packed {
        logic [31:0] addr_low;
        logic [31:0] addr_high;
        logic        main;
        logic        bufferable;
        logic        cacheable;
        logic        atomic;
    } pma_cfg_t;

    localparam pma_cfg_t PMA_R_DEFAULT = '{
        addr_low: 32'h0, addr_high: 32'h0, main: 1'b1,
        bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b0
    };

    // Attribute for addresses outside every configured region
    localparam pma_cfg_t PMA_R_IO = '{
        addr_low: 32'h0, addr_high: 32'h0, main: 1'b0,
        bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b0
    };

    typedef struct packed {
        logic err;
        logic we;
    } mpu_order_entry_t;

    function automatic logic pma_match(pma_cfg_t cfg, logic [31:0] addr);
        return (addr >= cfg.addr_low) && (addr < cfg.addr_high);
    endfunction

endpackage

// File: rtl/cv32e40x_mpu_resp_fifo.sv
// Small synchronous FIFO with wrapping pointers, used for both the
// MPU order queue and the buffered bus responses.
module cv32e40x_mpu_resp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         TYPE  = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  TYPE  wdata,
    input  logic pop,
    output TYPE  rdata,
    output logic empty,
    output logic full
);

    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    TYPE           mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_MAX);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/cv32e40x_pma.sv
// Physical memory attribute lookup; lowest-indexed matching region wins.
module cv32e40x_pma
    import cv32e40x_pkg::*;
#(
    parameter int       A_EXTENSION     = 0,
    parameter int       PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT}
) (
    input  logic [31:0] trans_addr_i,
    input  logic        instr_fetch_access_i,
    input  logic        atomic_access_i,
    input  logic        misaligned_access_i,
    output logic        pma_err_o,
    output logic        pma_bufferable_o,
    output logic        pma_cacheable_o
);

    logic main;
    logic atom;

    always_comb begin
        main             = (PMA_NUM_REGIONS == 0);
        atom             = 1'b0;
        pma_bufferable_o = 1'b0;
        pma_cacheable_o  = 1'b0;
        for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
            if (pma_match(PMA_CFG[i], trans_addr_i)) begin
                main             = PMA_CFG[i].main;
                atom             = PMA_CFG[i].atomic;
                pma_bufferable_o = PMA_CFG[i].bufferable;
                pma_cacheable_o  = PMA_CFG[i].cacheable;
            end
        end
    end

    assign pma_err_o = (!main && (instr_fetch_access_i || misaligned_access_i)) ||
                       ((A_EXTENSION != 0) && atomic_access_i && !atom);

endmodule

// File: rtl/cv32e40x_mpu_multi_outstanding.sv
// MPU with PMA checking and up to MAX_OUTSTANDING in-flight transactions;
// faults take an in-order slot so responses always return in request order.
module cv32e40x_mpu_multi_outstanding
    import cv32e40x_pkg::*;
#(
    parameter int       IF_STAGE        = 1,
    parameter int       A_EXTENSION     = 0,
    parameter type      CORE_REQ_TYPE   = obi_inst_req_t,
    parameter type      CORE_RESP_TYPE  = inst_resp_t,
    parameter type      BUS_RESP_TYPE   = obi_inst_resp_t,
    parameter int       PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
    parameter int       MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          atomic_access_i,
    input  logic          misaligned_access_i,
    input  logic          core_trans_valid_i,
    output logic          core_trans_ready_o,
    input  CORE_REQ_TYPE  core_trans_i,
    output logic          core_resp_valid_o,
    output CORE_RESP_TYPE core_resp_o,
    output logic          bus_trans_valid_o,
    input  logic          bus_trans_ready_i,
    output CORE_REQ_TYPE  bus_trans_o,
    input  logic          bus_resp_valid_i,
    input  BUS_RESP_TYPE  bus_resp_i
);

    localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic             instr_fetch;
    logic             trans_we;
    logic             pma_err;
    logic             pma_bufferable;
    logic             pma_cacheable;
    logic             full;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    out_cnt;
    mpu_order_entry_t q_head;
    logic             q_empty;
    logic             q_full;
    logic             pop_q;
    BUS_RESP_TYPE     rf_head;
    logic             rf_empty;
    logic             rf_full;
    logic             rf_push;
    logic             pop_rf;
    logic             bypass;

    generate
        if (IF_STAGE != 0) begin : mpu_if
            assign instr_fetch = 1'b1;
            assign trans_we    = 1'b0;
        end else begin : mpu_lsu
            assign instr_fetch = 1'b0;
            assign trans_we    = core_trans_i.we;
        end
    endgenerate

    cv32e40x_pma #(
        .A_EXTENSION     (A_EXTENSION),
        .PMA_NUM_REGIONS (PMA_NUM_REGIONS),
        .PMA_CFG         (PMA_CFG)
    ) pma_i (
        .trans_addr_i         (core_trans_i.addr),
        .instr_fetch_access_i (instr_fetch),
        .atomic_access_i      (atomic_access_i),
        .misaligned_access_i  (misaligned_access_i),
        .pma_err_o            (pma_err),
        .pma_bufferable_o     (pma_bufferable),
        .pma_cacheable_o      (pma_cacheable)
    );

    assign full               = (cnt == CNT_MAX);
    assign bus_trans_valid_o  = core_trans_valid_i && !full && !pma_err;
    assign core_trans_ready_o = !full && (pma_err || bus_trans_ready_i);
    assign accept             = core_trans_valid_i && core_trans_ready_o;

    always_comb begin
        bus_trans_o         = core_trans_i;
        bus_trans_o.memtype = {pma_cacheable, pma_bufferable};
    end

    cv32e40x_mpu_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TYPE  (mpu_order_entry_t)
    ) order_q_i (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (mpu_order_entry_t'{err: pma_err, we: trans_we}),
        .pop   (pop_q),
        .rdata (q_head),
        .empty (q_empty),
        .full  (q_full)
    );

    cv32e40x_mpu_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TYPE  (BUS_RESP_TYPE)
    ) resp_fifo_i (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rf_push),
        .wdata (bus_resp_i),
        .pop   (pop_rf),
        .rdata (rf_head),
        .empty (rf_empty),
        .full  (rf_full)
    );

    // Head of the order queue decides what the core sees this cycle
    always_comb begin
        core_resp_o            = '0;
        core_resp_o.mpu_status = MPU_OK;
        core_resp_valid_o      = 1'b0;
        pop_q                  = 1'b0;
        pop_rf                 = 1'b0;
        bypass                 = 1'b0;
        if (!q_empty) begin
            if (q_head.err) begin
                core_resp_valid_o      = 1'b1;
                core_resp_o.mpu_status = q_head.we ? MPU_WR_FAULT : MPU_RE_FAULT;
                pop_q                  = 1'b1;
            end else if (!rf_empty) begin
                core_resp_valid_o    = 1'b1;
                core_resp_o.bus_resp = rf_head;
                pop_q                = 1'b1;
                pop_rf               = 1'b1;
            end else if (bus_resp_valid_i) begin
                core_resp_valid_o    = 1'b1;
                core_resp_o.bus_resp = bus_resp_i;
                pop_q                = 1'b1;
                bypass               = 1'b1;
            end
        end
    end

    assign rf_push = bus_resp_valid_i && !bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            out_cnt <= '0;
        end else begin
            cnt     <= cnt + CW'(accept) - CW'(pop_q);
            out_cnt <= out_cnt + CW'(accept && !pma_err) - CW'(bus_resp_valid_i);
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && (full || q_full)));

    a_rf_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(rf_push && rf_full && !pop_rf));

    a_resp_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
        core_resp_valid_o |-> !q_empty);

    a_bus_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        bus_resp_valid_i |-> (out_cnt != '0));

endmodule
